forwarder_arbiter: RTL

//  Shares one AXI Stream forwarder between N_BUFS packet buffers (packetmem instances).

---
 rtl/forwarder_arbiter_if.sv | 57 +++++
 rtl/forwarder_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/forwarder_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : forwarder_arbiter_if
//  Description : Bundle of all buffer-side and forwarder-side signals that pass
//                through forwarder_arbiter.
//                slave  - arbiter view (requests/data in, enables/grant out)
//                master - environment view (buffers, forwarder, stream snoop)
//  Ports       : buf_* per-buffer request/length/data and read enable/done,
//                fwd_* muxed forwarder side, axis_* stream snoop,
//                grant_valid/grant_idx arbitration status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface forwarder_arbiter_if #(
    parameter int N_BUFS     = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9
);
    localparam int PLEN_WIDTH = ADDR_WIDTH + 1;
    localparam int IDX_WIDTH  = $clog2(N_BUFS);

    logic [N_BUFS-1:0]            buf_ready_for_fwd;
    logic [N_BUFS*PLEN_WIDTH-1:0] buf_len_to_fwd;
    logic [N_BUFS*DATA_WIDTH-1:0] buf_rd_data;
    logic [N_BUFS-1:0]            buf_rd_en;
    logic [ADDR_WIDTH-1:0]        buf_rd_addr;
    logic [N_BUFS-1:0]            buf_done;
    logic                         fwd_ready_for_fwd;
    logic [PLEN_WIDTH-1:0]        fwd_len_to_fwd;
    logic [DATA_WIDTH-1:0]        fwd_rd_data;
    logic [ADDR_WIDTH-1:0]        fwd_rd_addr;
    logic                         fwd_rd_en;
    logic                         fwd_done;
    logic                         axis_tvalid;
    logic                         axis_tready;
    logic                         axis_tlast;
    logic                         grant_valid;
    logic [IDX_WIDTH-1:0]         grant_idx;

    modport slave (
        input  buf_ready_for_fwd, buf_len_to_fwd, buf_rd_data,
               fwd_rd_addr, fwd_rd_en, fwd_done,
               axis_tvalid, axis_tready, axis_tlast,
        output buf_rd_en, buf_rd_addr, buf_done,
               fwd_ready_for_fwd, fwd_len_to_fwd, fwd_rd_data,
               grant_valid, grant_idx
    );

    modport master (
        output buf_ready_for_fwd, buf_len_to_fwd, buf_rd_data,
               fwd_rd_addr, fwd_rd_en, fwd_done,
               axis_tvalid, axis_tready, axis_tlast,
        input  buf_rd_en, buf_rd_addr, buf_done,
               fwd_ready_for_fwd, fwd_len_to_fwd, fwd_rd_data,
               grant_valid, grant_idx
    );
endinterface
`default_nettype wire

// File: rtl/forwarder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : forwarder_arbiter
//  Description : Round-robin share of one AXI Stream forwarder between N_BUFS
//                packet buffers. A grant is held from arbitration until the
//                last flit of the packet is accepted on the stream output.
//  Ports       : clk   - clock
//                rst_n - synchronous active-low reset
//                bus   - forwarder_arbiter_if.slave (buffer, forwarder,
//                        stream snoop and grant status signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module forwarder_arbiter #(
    parameter int N_BUFS     = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    forwarder_arbiter_if.slave   bus
);
    localparam int PLEN_WIDTH = ADDR_WIDTH + 1;
    localparam int IDX_WIDTH  = $clog2(N_BUFS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FWD   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic [IDX_WIDTH-1:0]  r_rr_ptr;
    logic [IDX_WIDTH-1:0]  r_grant_idx;
    logic                  r_grant_valid;

    logic                  w_any;
    logic [IDX_WIDTH-1:0]  w_winner;
    logic [IDX_WIDTH-1:0]  w_cand;
    logic                  w_fwd;
    logic                  w_last_beat;
    logic                  w_sel_ready;
    logic [PLEN_WIDTH-1:0] w_sel_len;
    logic [DATA_WIDTH-1:0] w_sel_data;

    // (base + off) mod N_BUFS with off < N_BUFS; explicit wrap so that a
    // non-power-of-2 buffer count never produces an unused index.
    function automatic logic [IDX_WIDTH-1:0] f_wrap_add(
        input logic [IDX_WIDTH-1:0] base,
        input int                   off
    );
        int sum;
        sum = int'(base) + off;
        if (sum >= N_BUFS) begin
            sum = sum - N_BUFS;
        end
        return sum[IDX_WIDTH-1:0];
    endfunction

    // Round-robin search. Offsets are scanned from the far end down so the
    // last hit, i.e. the one nearest r_rr_ptr, is the winner.
    always_comb begin
        w_any    = 1'b0;
        w_winner = r_rr_ptr;
        w_cand   = r_rr_ptr;
        for (int k = N_BUFS - 1; k >= 0; k--) begin
            w_cand = f_wrap_add(r_rr_ptr, k);
            if (bus.buf_ready_for_fwd[w_cand]) begin
                w_any    = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // Grantee slice selection; comparing against each constant index keeps
    // every part-select in range.
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_len   = '0;
        w_sel_data  = '0;
        for (int i = 0; i < N_BUFS; i++) begin
            if (r_grant_idx == IDX_WIDTH'(i)) begin
                w_sel_ready = bus.buf_ready_for_fwd[i];
                w_sel_len   = bus.buf_len_to_fwd[i*PLEN_WIDTH +: PLEN_WIDTH];
                w_sel_data  = bus.buf_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Gating with rst_n keeps a done pulse from reaching the buffer in the
    // reset cycle, so an abandoned packet stays in its buffer.
    assign w_fwd       = rst_n && (r_state == S_FWD);
    assign w_last_beat = bus.axis_tvalid & bus.axis_tready & bus.axis_tlast;

    always_comb begin
        bus.buf_rd_en = '0;
        bus.buf_done  = '0;
        for (int i = 0; i < N_BUFS; i++) begin
            if (w_fwd && (r_grant_idx == IDX_WIDTH'(i))) begin
                bus.buf_rd_en[i] = bus.fwd_rd_en;
                bus.buf_done[i]  = bus.fwd_done;
            end
        end
    end

    assign bus.fwd_ready_for_fwd = w_fwd & w_sel_ready;
    assign bus.fwd_len_to_fwd    = w_sel_len;
    // Data stays muxed through DRAIN so the registered last flit is presented.
    assign bus.fwd_rd_data       = w_sel_data;
    assign bus.buf_rd_addr       = bus.fwd_rd_addr;
    assign bus.grant_valid       = r_grant_valid;
    assign bus.grant_idx         = r_grant_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant_idx   <= w_winner;
                        r_grant_valid <= 1'b1;
                        r_state       <= S_FWD;
                    end
                end
                S_FWD: begin
                    if (bus.fwd_done) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_last_beat) begin
                        r_state       <= S_IDLE;
                        r_grant_valid <= 1'b0;
                        r_rr_ptr      <= f_wrap_add(r_grant_idx, 1);
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_grant_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
